// File: rtl/udma_i2c_slave.sv
// I2C target engine for the uDMA I2C peripheral: acknowledges its own 7-bit address,
// streams master writes to the RX channel and serves master reads from the TX channel.
module udma_i2c_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       sw_rst_i,
  input  logic       cfg_en_i,
  input  logic [6:0] cfg_addr_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oe,
  output logic [7:0] data_rx_o,
  output logic       data_rx_valid_o,
  input  logic       data_rx_ready_i,
  input  logic [7:0] data_tx_i,
  input  logic       data_tx_valid_i,
  output logic       data_tx_ready_o,
  output logic       evt_start_o,
  output logic       evt_stop_o,
  output logic       err_o
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;
  logic [6:0]             sr;
  logic [2:0]             cnt;
  logic                   rw, ld;
  logic [7:0]             tx_byte;

  assign sda_o = 1'b0;

  // Sync flops idle high so an idle bus never produces a spurious edge out of reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign tx_byte   = data_tx_valid_i ? data_tx_i : 8'hFF;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state           <= IDLE;
      sr              <= '0;
      cnt             <= '0;
      rw              <= 1'b0;
      ld              <= 1'b0;
      sda_oe          <= 1'b0;
      data_rx_o       <= '0;
      data_rx_valid_o <= 1'b0;
      data_tx_ready_o <= 1'b0;
      evt_start_o     <= 1'b0;
      evt_stop_o      <= 1'b0;
      err_o           <= 1'b0;
    end else if (sw_rst_i || !cfg_en_i) begin
      state           <= IDLE;
      sr              <= '0;
      cnt             <= '0;
      rw              <= 1'b0;
      ld              <= 1'b0;
      sda_oe          <= 1'b0;
      data_rx_o       <= '0;
      data_rx_valid_o <= 1'b0;
      data_tx_ready_o <= 1'b0;
      evt_start_o     <= 1'b0;
      evt_stop_o      <= 1'b0;
      err_o           <= 1'b0;
    end else begin
      data_tx_ready_o <= 1'b0;
      evt_start_o     <= 1'b0;
      evt_stop_o      <= 1'b0;
      err_o           <= 1'b0;
      // Clear first so a same-cycle set further down takes priority.
      if (data_rx_valid_o && data_rx_ready_i) data_rx_valid_o <= 1'b0;

      if (start_det) begin
        state       <= ADDR;
        cnt         <= '0;
        ld          <= 1'b0;
        sda_oe      <= 1'b0;
        evt_start_o <= 1'b1;
      end else if (stop_det) begin
        state      <= IDLE;
        cnt        <= '0;
        ld         <= 1'b0;
        sda_oe     <= 1'b0;
        evt_stop_o <= 1'b1;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            sr <= {sr[5:0], sda_s};
            if (cnt == 3'd7) begin
              cnt <= '0;
              rw  <= sda_s;
              if (sr == cfg_addr_i && cfg_addr_i != 7'd0) state <= ADDR_ACK;
              else                                        state <= IGNORE;
            end else cnt <= cnt + 3'd1;
          end
          // sda_oe doubles as the ACK phase flag: first fall drives, second fall ends the slot.
          ADDR_ACK: if (scl_fall) begin
            if (!sda_oe) sda_oe <= 1'b1;
            else begin
              cnt <= '0;
              if (rw) begin
                state           <= RD_DATA;
                sr              <= tx_byte[6:0];
                sda_oe          <= ~tx_byte[7];
                data_tx_ready_o <= data_tx_valid_i;
                err_o           <= ~data_tx_valid_i;
              end else begin
                state  <= WR_DATA;
                sda_oe <= 1'b0;
              end
            end
          end
          WR_DATA: if (scl_rise) begin
            sr <= {sr[5:0], sda_s};
            if (cnt == 3'd7) begin
              cnt <= '0;
              if (data_rx_valid_o) begin
                err_o <= 1'b1;
                state <= IGNORE;
              end else begin
                data_rx_o       <= {sr, sda_s};
                data_rx_valid_o <= 1'b1;
                state           <= WR_ACK;
              end
            end else cnt <= cnt + 3'd1;
          end
          WR_ACK: if (scl_fall) begin
            if (!sda_oe) sda_oe <= 1'b1;
            else begin
              sda_oe <= 1'b0;
              state  <= WR_DATA;
            end
          end
          RD_DATA: if (scl_fall) begin
            if (ld) begin
              ld              <= 1'b0;
              cnt             <= '0;
              sr              <= tx_byte[6:0];
              sda_oe          <= ~tx_byte[7];
              data_tx_ready_o <= data_tx_valid_i;
              err_o           <= ~data_tx_valid_i;
            end else if (cnt == 3'd7) begin
              cnt    <= '0;
              sda_oe <= 1'b0;
              state  <= RD_ACK;
            end else begin
              sr     <= {sr[5:0], 1'b0};
              sda_oe <= ~sr[6];
              cnt    <= cnt + 3'd1;
            end
          end
          // Master ACK arms a load on the falling edge that closes the ACK slot.
          RD_ACK: if (scl_rise) begin
            if (sda_s) state <= IGNORE;
            else begin
              state <= RD_DATA;
              ld    <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_udma_i2c_slave.sv
// Bench for udma_i2c_slave: a bus-level I2C master model with wired-AND SDA and
// transaction-level expectations derived from address/ACK/data rules.
module tb_udma_i2c_slave;
  localparam int H = 12;

  logic       clk = 1'b0, rstn = 1'b0, sw_rst = 1'b0, cfg_en = 1'b0;
  logic [6:0] cfg_addr = 7'h00;
  logic       scl = 1'b1, m_sda = 1'b1;
  logic       sda_bus;
  logic       sda_o, sda_oe;
  logic [7:0] data_rx;
  logic       data_rx_valid, data_rx_ready = 1'b1;
  logic [7:0] data_tx;
  logic       data_tx_valid = 1'b0, data_tx_ready;
  logic       evt_start, evt_stop, err;

  logic [7:0] tx_mem [0:255];
  logic [7:0] rx_log [0:255];
  int n_start = 0, n_stop = 0, n_err = 0, n_txr = 0, n_oe = 0, rx_n = 0, tx_cnt = 0;
  int n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;
  assign sda_bus = m_sda & ~sda_oe;
  assign data_tx = tx_mem[tx_cnt];

  udma_i2c_slave #(.SYNC_STAGES(2)) dut (
    .clk_i(clk), .rstn_i(rstn), .sw_rst_i(sw_rst), .cfg_en_i(cfg_en), .cfg_addr_i(cfg_addr),
    .scl_i(scl), .sda_i(sda_bus), .sda_o(sda_o), .sda_oe(sda_oe),
    .data_rx_o(data_rx), .data_rx_valid_o(data_rx_valid), .data_rx_ready_i(data_rx_ready),
    .data_tx_i(data_tx), .data_tx_valid_i(data_tx_valid), .data_tx_ready_o(data_tx_ready),
    .evt_start_o(evt_start), .evt_stop_o(evt_stop), .err_o(err)
  );

  // Pulses are counted per high cycle, so a stretched strobe shows up as an extra count.
  always @(negedge clk) begin
    if (evt_start) n_start++;
    if (evt_stop) n_stop++;
    if (err) n_err++;
    if (data_tx_ready) tx_cnt++;
    if (data_tx_ready) n_txr++;
    if (sda_oe) n_oe++;
    if (data_rx_valid && data_rx_ready) begin
      rx_log[rx_n] = data_rx;
      rx_n++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clk_bit(input logic b, output logic r);
    wait_clk(3); m_sda = b;
    wait_clk(H); scl = 1'b1;
    wait_clk(H/2); r = sda_bus;
    wait_clk(H/2); scl = 1'b0;
  endtask

  task automatic bus_start();
    wait_clk(3); m_sda = 1'b1;
    wait_clk(H); scl = 1'b1;
    wait_clk(H); m_sda = 1'b0;
    wait_clk(H); scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(3); m_sda = 1'b0;
    wait_clk(H); scl = 1'b1;
    wait_clk(H); m_sda = 1'b1;
    wait_clk(H);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
    clk_bit(1'b1, ack);
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, r);
      b[i] = r;
    end
    clk_bit(mack, r);
  endtask

  task automatic test_reset();
    logic [19:0] outs;
    rstn = 1'b0; cfg_en = 1'b1; cfg_addr = 7'h42;
    wait_clk(4);
    outs = {sda_o, sda_oe, data_rx, data_rx_valid, data_tx_ready, evt_start, evt_stop, err, 4'h0};
    n_cmp++; if (outs !== 20'h0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", outs); end
    rstn = 1'b1; sw_rst = 1'b1;
    wait_clk(4);
    outs = {sda_o, sda_oe, data_rx, data_rx_valid, data_tx_ready, evt_start, evt_stop, err, 4'h0};
    n_cmp++; if (outs !== 20'h0) begin n_fail++; $display("FAIL swrst_outputs: got %h want 0", outs); end
    sw_rst = 1'b0;
    wait_clk(10);
    n_cmp++; if (n_start !== 0) begin n_fail++; $display("FAIL idle_no_start: got %0d want 0", n_start); end
  endtask

  task automatic test_write();
    logic a0, a1, a2; int s0 = n_start, p0 = n_stop, r0 = rx_n;
    data_rx_ready = 1'b1;
    bus_start();
    wr_byte(8'h84, a0); wr_byte(8'hA5, a1); wr_byte(8'h3C, a2);
    bus_stop();
    n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL write_acks: got %b want 000", {a0, a1, a2}); end
    n_cmp++; if (rx_n - r0 !== 2) begin n_fail++; $display("FAIL write_rx_count: got %0d want 2", rx_n - r0); end
    n_cmp++; if ({rx_log[r0], rx_log[r0+1]} !== 16'hA53C) begin n_fail++; $display("FAIL write_rx_data: got %h want a53c", {rx_log[r0], rx_log[r0+1]}); end
    n_cmp++; if ({n_start - s0, n_stop - p0} !== {32'd1, 32'd1}) begin n_fail++; $display("FAIL write_events: got start=%0d stop=%0d want 1/1", n_start - s0, n_stop - p0); end
  endtask

  task automatic test_read();
    logic a; logic [7:0] b0, b1; int t0 = n_txr, e0 = n_err;
    tx_mem[tx_cnt] = 8'h5A; tx_mem[tx_cnt+1] = 8'hC3; data_tx_valid = 1'b1;
    bus_start();
    wr_byte(8'h85, a);
    rd_byte(1'b0, b0); rd_byte(1'b1, b1);
    n_cmp++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL read_release_after_nack: got %b want 0", sda_oe); end
    bus_stop();
    n_cmp++; if (a !== 1'b0) begin n_fail++; $display("FAIL read_addr_ack: got %b want 0", a); end
    n_cmp++; if ({b0, b1} !== 16'h5AC3) begin n_fail++; $display("FAIL read_data: got %h want 5ac3", {b0, b1}); end
    n_cmp++; if (n_txr - t0 !== 2) begin n_fail++; $display("FAIL read_tx_ready: got %0d want 2", n_txr - t0); end
    n_cmp++; if (n_err - e0 !== 0) begin n_fail++; $display("FAIL read_err: got %0d want 0", n_err - e0); end
    data_tx_valid = 1'b0;
  endtask

  task automatic test_nomatch();
    logic a0, a1, a2; int o0 = n_oe, r0 = rx_n, t0 = n_txr;
    data_tx_valid = 1'b1;
    bus_start();
    wr_byte(8'h86, a0); wr_byte(8'h55, a1);
    bus_stop();
    cfg_en = 1'b0;
    bus_start(); wr_byte(8'h84, a2); bus_stop();
    cfg_en = 1'b1;
    n_cmp++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL nomatch_acks: got %b want 111", {a0, a1, a2}); end
    n_cmp++; if (n_oe - o0 !== 0) begin n_fail++; $display("FAIL nomatch_sda_driven: got %0d cycles want 0", n_oe - o0); end
    n_cmp++; if ({rx_n - r0, n_txr - t0} !== {32'd0, 32'd0}) begin n_fail++; $display("FAIL nomatch_strobes: got rx=%0d tx=%0d want 0/0", rx_n - r0, n_txr - t0); end
    data_tx_valid = 1'b0;
  endtask

  task automatic test_rx_overflow();
    logic a0, a1, a2; int e0 = n_err;
    data_rx_ready = 1'b0;
    bus_start();
    wr_byte(8'h84, a0); wr_byte(8'h11, a1); wr_byte(8'h22, a2);
    bus_stop();
    n_cmp++; if ({a0, a1, a2} !== 3'b001) begin n_fail++; $display("FAIL ovf_acks: got %b want 001", {a0, a1, a2}); end
    n_cmp++; if (n_err - e0 !== 1) begin n_fail++; $display("FAIL ovf_err: got %0d want 1", n_err - e0); end
    n_cmp++; if ({data_rx_valid, data_rx} !== 9'h111) begin n_fail++; $display("FAIL ovf_hold: got %h want 111", {data_rx_valid, data_rx}); end
    sw_rst = 1'b1; wait_clk(2); sw_rst = 1'b0;
    n_cmp++; if ({data_rx_valid, data_rx} !== 9'h000) begin n_fail++; $display("FAIL swrst_hold: got %h want 000", {data_rx_valid, data_rx}); end
    data_rx_ready = 1'b1;
  endtask

  task automatic test_tx_underrun();
    logic a; logic [7:0] b; int e0 = n_err, t0 = n_txr;
    data_tx_valid = 1'b0;
    bus_start(); wr_byte(8'h85, a); rd_byte(1'b1, b); bus_stop();
    n_cmp++; if ({a, b} !== 9'h0FF) begin n_fail++; $display("FAIL underrun_data: got %h want 0ff", {a, b}); end
    n_cmp++; if ({n_err - e0, n_txr - t0} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL underrun_strobes: got err=%0d txr=%0d want 1/0", n_err - e0, n_txr - t0); end
  endtask

  task automatic test_restart();
    logic a0, a1, r; logic [7:0] b; int r0 = rx_n;
    data_rx_ready = 1'b1;
    tx_mem[tx_cnt] = 8'h96; data_tx_valid = 1'b1;
    bus_start(); wr_byte(8'h84, a0);
    for (int i = 0; i < 4; i++) clk_bit(1'b1, r);
    bus_start(); wr_byte(8'h85, a1); rd_byte(1'b1, b); bus_stop();
    n_cmp++; if ({a0, a1} !== 2'b00) begin n_fail++; $display("FAIL restart_acks: got %b want 00", {a0, a1}); end
    n_cmp++; if (rx_n - r0 !== 0) begin n_fail++; $display("FAIL restart_partial: got %0d bytes want 0", rx_n - r0); end
    n_cmp++; if (b !== 8'h96) begin n_fail++; $display("FAIL restart_read: got %h want 96", b); end
    // Async reset while the target is pulling SDA low mid-byte.
    tx_mem[tx_cnt] = 8'h00;
    bus_start(); wr_byte(8'h85, a0);
    for (int i = 0; i < 3; i++) clk_bit(1'b1, r);
    n_cmp++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL midbyte_drive: got %b want 1", sda_oe); end
    @(posedge clk); #2 rstn = 1'b0; #1;
    n_cmp++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL async_reset_release: got %b want 0", sda_oe); end
    wait_clk(3); rstn = 1'b1;
    bus_stop();
    data_tx_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      logic [6:0] cfg, a; logic rw, tv, match, ack; logic [7:0] rb, want;
      logic [7:0] bytes [0:3]; logic [7:0] exp_rx [0:3];
      int n, ne, e0, t0, r0;
      cfg = 7'($urandom_range(1, 127));
      a = ($urandom_range(0, 1) == 1) ? cfg : 7'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) begin cfg = 7'd0; a = 7'd0; end
      rw = 1'($urandom_range(0, 1)); tv = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 3); ne = 0;
      match = (a == cfg) && (a != 7'd0);
      for (int k = 0; k < n; k++) begin
        bytes[k] = 8'($urandom);
        if (rw) tx_mem[tx_cnt + k] = bytes[k];
      end
      cfg_en = 1'b0; cfg_addr = cfg; wait_clk(2); cfg_en = 1'b1;
      data_tx_valid = tv;
      e0 = n_err; t0 = n_txr; r0 = rx_n;
      bus_start();
      wr_byte({a, rw}, ack);
      n_cmp++; if (ack !== !match) begin n_fail++; $display("FAIL rnd%0d_addr_ack: got %b want %b", it, ack, !match); end
      for (int k = 0; k < n; k++) begin
        if (!rw) begin
          wr_byte(bytes[k], ack);
          n_cmp++; if (ack !== !match) begin n_fail++; $display("FAIL rnd%0d_wr_ack%0d: got %b want %b", it, k, ack, !match); end
          if (match) begin exp_rx[ne] = bytes[k]; ne++; end
        end else begin
          rd_byte(k == n - 1, rb);
          want = (match && tv) ? bytes[k] : 8'hFF;
          n_cmp++; if (rb !== want) begin n_fail++; $display("FAIL rnd%0d_rd_data%0d: got %h want %h", it, k, rb, want); end
        end
      end
      bus_stop();
      n_cmp++; if (rx_n - r0 !== ne) begin n_fail++; $display("FAIL rnd%0d_rx_count: got %0d want %0d", it, rx_n - r0, ne); end
      for (int k = 0; k < ne && k < rx_n - r0; k++) begin
        n_cmp++; if (rx_log[r0 + k] !== exp_rx[k]) begin n_fail++; $display("FAIL rnd%0d_rx%0d: got %h want %h", it, k, rx_log[r0 + k], exp_rx[k]); end
      end
      n_cmp++; if (n_err - e0 !== ((match && rw && !tv) ? n : 0)) begin n_fail++; $display("FAIL rnd%0d_err: got %0d want %0d", it, n_err - e0, (match && rw && !tv) ? n : 0); end
      n_cmp++; if (n_txr - t0 !== ((match && rw && tv) ? n : 0)) begin n_fail++; $display("FAIL rnd%0d_txr: got %0d want %0d", it, n_txr - t0, (match && rw && tv) ? n : 0); end
    end
    data_tx_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tx_mem[i] = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_nomatch();
    test_rx_overflow();
    test_tx_underrun();
    cfg_addr = 7'h42;
    test_restart();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
